// File: rtl/mix_arith_unit.sv
// MIX arithmetic unit: sign-magnitude add, signed compare and restoring divide.
// The three units run independently and each has its own start/stop handshake.
module mix_arith_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [30:0] a,
  input  logic [30:0] b,
  input  logic [29:0] x,
  input  logic        add_start,
  input  logic        cmp_start,
  input  logic        div_start,
  output logic        add_stop,
  output logic        cmp_stop,
  output logic        div_stop,
  output logic [30:0] sum,
  output logic        add_of,
  output logic        less,
  output logic        equal,
  output logic        greater,
  output logic [29:0] quotient,
  output logic [29:0] remainder,
  output logic        q_sign,
  output logic        r_sign,
  output logic        div_of,
  output logic        div_busy
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} divState_t;

  logic [30:0] sum_q, sum_d;
  logic        addOf_q, addOf_d, addStop_q;
  logic [30:0] magSum;
  logic [29:0] addMag;
  logic        addSign;

  logic less_q, equal_q, greater_q, cmpStop_q;
  logic less_d, equal_d, greater_d;

  divState_t   state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [29:0] rem_q, rem_d;
  logic [29:0] low_q, low_d;
  logic [28:0] quo_q, quo_d;
  logic [29:0] divisor_q, divisor_d;
  logic        pendQSign_q, pendQSign_d, pendRSign_q, pendRSign_d;
  logic [29:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic        qSign_q, qSign_d, rSign_q, rSign_d, divOf_q, divOf_d;
  logic [30:0] trial;
  logic        trialBit;
  logic [29:0] trialRem;

  // Sign-magnitude sum of a and b; a zero magnitude keeps the sign of a.
  always_comb begin
    magSum  = {1'b0, a[29:0]} + {1'b0, b[29:0]};
    addOf_d = 1'b0;
    addMag  = magSum[29:0];
    addSign = a[30];
    if (a[30] != b[30]) begin
      if (a[29:0] >= b[29:0]) begin
        addMag  = a[29:0] - b[29:0];
        addSign = a[30];
      end else begin
        addMag  = b[29:0] - a[29:0];
        addSign = b[30];
      end
    end else begin
      addOf_d = magSum[30];
    end
    if (addMag == 30'd0) addSign = a[30];
    sum_d = {addSign, addMag};
  end

  // Add result registers; results are captured on the start edge so stop follows one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q     <= '0;
      addOf_q   <= 1'b0;
      addStop_q <= 1'b0;
    end else begin
      addStop_q <= add_start;
      if (add_start) begin
        sum_q   <= sum_d;
        addOf_q <= addOf_d;
      end
    end
  end

  // Signed compare where +0 and -0 are the same value.
  always_comb begin
    less_d    = 1'b0;
    equal_d   = 1'b0;
    greater_d = 1'b0;
    if (a[29:0] == 30'd0 && b[29:0] == 30'd0) equal_d = 1'b1;
    else if (a[30] != b[30]) begin
      if (a[30]) less_d = 1'b1;
      else       greater_d = 1'b1;
    end
    else if (a[29:0] == b[29:0]) equal_d = 1'b1;
    else if ((a[29:0] > b[29:0]) ^ a[30]) greater_d = 1'b1;
    else less_d = 1'b1;
  end

  // Compare flag registers; flags only change when a compare completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
      cmpStop_q <= 1'b0;
    end else begin
      cmpStop_q <= cmp_start;
      if (cmp_start) begin
        less_q    <= less_d;
        equal_q   <= equal_d;
        greater_q <= greater_d;
      end
    end
  end

  // Divider next state: overflow finishes at once, otherwise one restoring step per cycle.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    low_d       = low_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    pendQSign_d = pendQSign_q;
    pendRSign_d = pendRSign_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    qSign_d     = qSign_q;
    rSign_d     = rSign_q;
    divOf_d     = divOf_q;
    trial       = {rem_q, low_q[29]};
    trialBit    = (trial >= {1'b0, divisor_q});
    trialRem    = trialBit ? (trial[29:0] - divisor_q) : trial[29:0];
    case (state_q)
      DIV_IDLE: begin
        if (div_start) begin
          if (b[29:0] == 30'd0 || a[29:0] >= b[29:0]) begin
            divOf_d     = 1'b1;
            quotient_d  = '0;
            remainder_d = '0;
            qSign_d     = a[30] ^ b[30];
            rSign_d     = a[30];
            state_d     = DIV_DONE;
          end else begin
            divisor_d   = b[29:0];
            rem_d       = a[29:0];
            low_d       = x;
            quo_d       = '0;
            count_d     = 5'd0;
            pendQSign_d = a[30] ^ b[30];
            pendRSign_d = a[30];
            state_d     = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        rem_d   = trialRem;
        low_d   = {low_q[28:0], 1'b0};
        quo_d   = {quo_q[27:0], trialBit};
        count_d = count_q + 5'd1;
        if (count_q == 5'd29) begin
          quotient_d  = {quo_q, trialBit};
          remainder_d = trialRem;
          qSign_d     = pendQSign_q;
          rSign_d     = pendRSign_q;
          divOf_d     = 1'b0;
          state_d     = DIV_DONE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Divider registers; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      low_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      pendQSign_q <= 1'b0;
      pendRSign_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      qSign_q     <= 1'b0;
      rSign_q     <= 1'b0;
      divOf_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      low_q       <= low_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      pendQSign_q <= pendQSign_d;
      pendRSign_q <= pendRSign_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      qSign_q     <= qSign_d;
      rSign_q     <= rSign_d;
      divOf_q     <= divOf_d;
    end
  end

  assign add_stop  = addStop_q;
  assign sum       = sum_q;
  assign add_of    = addOf_q;
  assign cmp_stop  = cmpStop_q;
  assign less      = less_q;
  assign equal     = equal_q;
  assign greater   = greater_q;
  assign div_stop  = (state_q == DIV_DONE);
  assign div_busy  = (state_q != DIV_IDLE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign q_sign    = qSign_q;
  assign r_sign    = rSign_q;
  assign div_of    = divOf_q;

endmodule

// File: tb/tb_mix_arith_unit.sv
// Testbench for mix_arith_unit: directed and random operations against a value-level model.
module tb_mix_arith_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [30:0] a, b;
  logic [29:0] x;
  logic        add_start, cmp_start, div_start;
  logic        add_stop, cmp_stop, div_stop;
  logic [30:0] sum;
  logic        add_of, less, equal, greater;
  logic [29:0] quotient, remainder;
  logic        q_sign, r_sign, div_of, div_busy;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [30:0] NEG = 31'h4000_0000;

  mix_arith_unit dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .x(x),
    .add_start(add_start), .cmp_start(cmp_start), .div_start(div_start),
    .add_stop(add_stop), .cmp_stop(cmp_stop), .div_stop(div_stop),
    .sum(sum), .add_of(add_of), .less(less), .equal(equal), .greater(greater),
    .quotient(quotient), .remainder(remainder), .q_sign(q_sign), .r_sign(r_sign),
    .div_of(div_of), .div_busy(div_busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Signed integer value of a MIX word.
  function automatic longint mixValue(input logic [30:0] w);
    longint m;
    m = longint'(w[29:0]);
    return w[30] ? -m : m;
  endfunction

  // Returns {overflow, sum word}.
  function automatic logic [31:0] modelAdd(input logic [30:0] av, input logic [30:0] bv);
    longint r, mag;
    logic s;
    r   = mixValue(av) + mixValue(bv);
    mag = (r < 0) ? -r : r;
    s   = (r < 0) ? 1'b1 : (r > 0) ? 1'b0 : av[30];
    return {(mag >= 64'sh4000_0000), s, mag[29:0]};
  endfunction

  // Returns {less, equal, greater}.
  function automatic logic [2:0] modelCmp(input logic [30:0] av, input logic [30:0] bv);
    longint va, vb;
    va = mixValue(av);
    vb = mixValue(bv);
    return {va < vb, va == vb, va > vb};
  endfunction

  task automatic modelDiv(input logic [30:0] av, input logic [30:0] bv, input logic [29:0] xv,
                          output logic eOf, output logic [29:0] eQ, output logic [29:0] eR,
                          output logic eQs, output logic eRs, output int eCycles);
    logic [63:0] dividend, divisor;
    dividend = {4'd0, av[29:0], xv};
    divisor  = {34'd0, bv[29:0]};
    eQs = av[30] ^ bv[30];
    eRs = av[30];
    if (divisor == 64'd0 || av[29:0] >= bv[29:0]) begin
      eOf = 1'b1; eQ = '0; eR = '0; eCycles = 1;
    end else begin
      eOf = 1'b0; eQ = 30'(dividend / divisor); eR = 30'(dividend % divisor); eCycles = 31;
    end
  endtask

  // Drive operands and start pulses for one cycle; returns in the cycle after the start edge.
  task automatic applyStimulus(input logic addS, input logic cmpS, input logic divS,
                               input logic [30:0] av, input logic [30:0] bv, input logic [29:0] xv);
    @(negedge clk);
    a = av; b = bv; x = xv;
    add_start = addS; cmp_start = cmpS; div_start = divS;
    @(negedge clk);
    add_start = 1'b0; cmp_start = 1'b0; div_start = 1'b0;
  endtask

  task automatic checkAdd(input string tag, input logic [30:0] av, input logic [30:0] bv);
    logic [31:0] e;
    e = modelAdd(av, bv);
    checkOutput({tag, ".stop"}, add_stop, 1'b1);
    checkOutput({tag, ".sum"}, sum, e[30:0]);
    checkOutput({tag, ".of"}, add_of, e[31]);
  endtask

  task automatic checkCmp(input string tag, input logic [30:0] av, input logic [30:0] bv);
    checkOutput({tag, ".stop"}, cmp_stop, 1'b1);
    checkOutput({tag, ".flags"}, {less, equal, greater}, modelCmp(av, bv));
  endtask

  // Wait for div_stop (bounded) from the cycle after div_start and check the result.
  task automatic waitDiv(input string tag, input logic [30:0] av, input logic [30:0] bv, input logic [29:0] xv);
    logic eOf, eQs, eRs;
    logic [29:0] eQ, eR;
    int eCycles, cycles;
    modelDiv(av, bv, xv, eOf, eQ, eR, eQs, eRs, eCycles);
    cycles = 1;
    checkOutput({tag, ".busy"}, div_busy, 1'b1);
    while (!div_stop && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, ".latency"}, cycles, eCycles);
    checkOutput({tag, ".busyAtStop"}, div_busy, 1'b1);
    checkOutput({tag, ".of"}, div_of, eOf);
    checkOutput({tag, ".q"}, quotient, eQ);
    checkOutput({tag, ".r"}, remainder, eR);
    checkOutput({tag, ".signs"}, {q_sign, r_sign}, {eQs, eRs});
    @(negedge clk);
    checkOutput({tag, ".stopLow"}, {div_stop, div_busy}, 2'b00);
  endtask

  task automatic doAdd(input string tag, input logic [30:0] av, input logic [30:0] bv);
    applyStimulus(1'b1, 1'b0, 1'b0, av, bv, 30'd0);
    checkAdd(tag, av, bv);
  endtask

  task automatic doCmp(input string tag, input logic [30:0] av, input logic [30:0] bv);
    applyStimulus(1'b0, 1'b1, 1'b0, av, bv, 30'd0);
    checkCmp(tag, av, bv);
  endtask

  task automatic doDiv(input string tag, input logic [30:0] av, input logic [30:0] bv, input logic [29:0] xv);
    applyStimulus(1'b0, 1'b0, 1'b1, av, bv, xv);
    waitDiv(tag, av, bv, xv);
  endtask

  // Directed steps followed by randomized operations.
  initial begin
    int stops;
    logic [30:0] ra, rb;
    logic [29:0] rx, mb;
    logic [2:0] savedFlags;
    logic eOf, eQs, eRs;
    logic [29:0] eQ, eR;
    int eCycles;

    a = '0; b = '0; x = '0;
    add_start = 1'b1; cmp_start = 1'b1; div_start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.flags", {add_stop, cmp_stop, div_stop, add_of, div_of, div_busy, less, equal, greater}, 9'd0);
    checkOutput("reset.data", {sum, quotient, remainder, q_sign, r_sign}, 93'd0);
    reset = 1'b0;
    add_start = 1'b0; cmp_start = 1'b0; div_start = 1'b0;
    @(negedge clk);
    checkOutput("reset.noStop", {add_stop, cmp_stop, div_stop, div_busy}, 4'd0);

    doAdd("add.5m7", 31'd5, NEG | 31'd7);
    checkOutput("add.5m7.value", sum, NEG | 31'd2);
    @(negedge clk);
    checkOutput("add.stopLow", add_stop, 1'b0);
    doAdd("add.ovf", 31'h3FFF_FFFF, 31'd1);
    checkOutput("add.ovf.value", {add_of, sum}, {1'b1, 31'd0});
    doAdd("add.negZero", NEG | 31'd3, 31'd3);
    checkOutput("add.negZero.value", sum, NEG);
    doAdd("add.negOvf", NEG | 31'h3FFF_FFFF, NEG | 31'd5);

    doCmp("cmp.zeros", 31'd0, NEG);
    checkOutput("cmp.zeros.equal", equal, 1'b1);
    doCmp("cmp.m4p2", NEG | 31'd4, 31'd2);
    checkOutput("cmp.m4p2.less", less, 1'b1);
    doCmp("cmp.9p8", 31'd9, 31'd8);
    checkOutput("cmp.9p8.greater", greater, 1'b1);
    savedFlags = {less, equal, greater};
    doAdd("add.holdCmp", 31'd1, 31'd1);
    checkOutput("cmp.hold", {cmp_stop, less, equal, greater}, {1'b0, savedFlags});

    doDiv("div.example", 31'd0, NEG | 31'd7, 30'd100);
    checkOutput("div.example.value", {quotient, remainder, q_sign, r_sign}, {30'd14, 30'd2, 1'b1, 1'b0});
    doDiv("div.zeroDivisor", 31'd3, NEG, 30'd9);
    doDiv("div.aGeB", 31'd5, 31'd5, 30'd1);

    applyStimulus(1'b1, 1'b1, 1'b1, 31'd5, NEG | 31'd7, 30'd100);
    checkAdd("all.add", 31'd5, NEG | 31'd7);
    checkCmp("all.cmp", 31'd5, NEG | 31'd7);
    waitDiv("all.div", 31'd5, NEG | 31'd7, 30'd100);

    applyStimulus(1'b0, 1'b0, 1'b1, 31'd0, NEG | 31'd7, 30'd100);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort.busy", div_busy, 1'b0);
    stops = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_stop) stops++;
    end
    checkOutput("abort.noStop", stops, 0);
    checkOutput("abort.quotient", quotient, 30'd0);

    modelDiv(31'd3, 31'd11, 30'd12345, eOf, eQ, eR, eQs, eRs, eCycles);
    applyStimulus(1'b0, 1'b0, 1'b1, 31'd3, 31'd11, 30'd12345);
    stops = div_stop ? 1 : 0;
    for (int i = 2; i <= 45; i++) begin
      if (i == 5) begin
        b = 31'd0;
        div_start = 1'b1;
      end
      @(negedge clk);
      div_start = 1'b0;
      if (div_stop) stops++;
    end
    checkOutput("busy.oneStop", stops, 1);
    checkOutput("busy.result", {div_of, quotient, remainder}, {eOf, eQ, eR});

    for (int i = 0; i < 16; i++) begin
      ra = 31'($urandom);
      rb = 31'($urandom);
      if (i % 3 == 0) begin
        ra[29:0] = 30'($urandom_range(0, 3));
        rb[29:0] = 30'($urandom_range(0, 3));
      end
      if (i % 5 == 1) ra[29:0] = rb[29:0];
      doAdd("rand.add", ra, rb);
      doCmp("rand.cmp", ra, rb);
    end

    for (int i = 0; i < 6; i++) begin
      mb = 30'($urandom) | 30'd1;
      ra = {1'($urandom), 30'($urandom % {2'b00, mb})};
      if (i == 5) ra[29:0] = mb;
      rb = {1'($urandom), mb};
      rx = 30'($urandom);
      doDiv("rand.div", ra, rb, rx);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
